// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle ARM main controller.
//   - state encoding for the controller FSM
//   - immediate-extender class codes (ImmSrc)
//   - datapath mux select encodings (ALUSrcA, ALUSrcB, ResultSrc)
//   - ALU command codes and the data-processing Funct[4:1] opcodes
package ctrl_pkg;

   // Controller states
   typedef logic [3:0] state_t;
   localparam state_t S_FETCH   = 4'd0;
   localparam state_t S_DECODE  = 4'd1;
   localparam state_t S_MEMADR  = 4'd2;
   localparam state_t S_MEMRD   = 4'd3;
   localparam state_t S_MEMWB   = 4'd4;
   localparam state_t S_MEMWR   = 4'd5;
   localparam state_t S_EXECR   = 4'd6;
   localparam state_t S_EXECI   = 4'd7;
   localparam state_t S_ALUWB   = 4'd8;
   localparam state_t S_BRANCH  = 4'd9;
   localparam state_t S_UNKNOWN = 4'd10;

   // Immediate extender classes
   localparam logic [1:0] IMM_ROT = 2'b00;  // rotated imm8
   localparam logic [1:0] IMM_U12 = 2'b01;  // zero-extended imm12
   localparam logic [1:0] IMM_B24 = 2'b10;  // sign-extended imm24 << 2

   // ALU operand A select
   localparam logic [1:0] SRCA_RA  = 2'b00;
   localparam logic [1:0] SRCA_PC  = 2'b01;
   localparam logic [1:0] SRCA_ALT = 2'b10;  // branch target base

   // ALU operand B select
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALU commands
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   // Instruction class, Instr[27:26]
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_UNK = 2'b11;

   // Data-processing command field, Funct[4:1]
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational instruction field decode.
//   op          in  2  Instr[27:26]
//   funct       in  6  Instr[25:20]
//   alu_control out 2  ALU command for execute states
//   flag_mask   out 2  flag write enables before condition gating ([1]=NZ, [0]=CV)
//   imm_src     out 2  immediate class for the extender
//   is_cmp      out 1  compare: no register writeback
//   is_imm      out 1  data-processing with immediate operand
//   is_load     out 1  memory access is a load
//   illegal     out 1  unsupported instruction
module instr_decoder
   import ctrl_pkg::*;
(
   input  logic [1:0] op,
   input  logic [5:0] funct,
   output logic [1:0] alu_control,
   output logic [1:0] flag_mask,
   output logic [1:0] imm_src,
   output logic       is_cmp,
   output logic       is_imm,
   output logic       is_load,
   output logic       illegal
);

   logic [1:0] cmd_mask;

   always_comb begin
      alu_control = ALU_ADD;
      cmd_mask    = 2'b00;
      imm_src     = IMM_ROT;
      is_cmp      = 1'b0;
      illegal     = 1'b0;
      case (op)
         OP_DP: begin
            case (funct[4:1])
               CMD_ADD: begin alu_control = ALU_ADD; cmd_mask = 2'b11; end
               CMD_SUB: begin alu_control = ALU_SUB; cmd_mask = 2'b11; end
               CMD_CMP: begin alu_control = ALU_SUB; cmd_mask = 2'b11; is_cmp = 1'b1; end
               // Logical ops leave C and V untouched
               CMD_AND: begin alu_control = ALU_AND; cmd_mask = 2'b10; end
               CMD_ORR: begin alu_control = ALU_ORR; cmd_mask = 2'b10; end
               default: illegal = 1'b1;
            endcase
         end
         OP_MEM:  imm_src = IMM_U12;
         OP_BR:   imm_src = IMM_B24;
         OP_UNK:  illegal = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

   // Flags only update when the S bit is set
   assign flag_mask = cmd_mask & {2{funct[0]}};
   assign is_imm    = funct[5];
   assign is_load   = funct[0];

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle ARM main controller (Moore FSM) plus decoder.
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   Op/Funct/Rd in  instruction fields from the instruction register
//   CondEx     in   condition check passed
//   MemReady   in   memory completes the current access this cycle
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc,
//   RegSrc, PCWrite, RegWrite, MemWrite, FlagW  out  datapath controls
//   Illegal    out  one-cycle pulse on an unsupported instruction
module mc_control_fsm
   import ctrl_pkg::*;
#(
   parameter state_t RESET_STATE = S_FETCH
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic       CondEx,
   input  logic       MemReady,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUControl,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [1:0] FlagW,
   output logic       Illegal
);

   state_t     state_reg, state_next, out_state;
   logic [1:0] op_reg;
   logic [5:0] funct_reg;
   logic [3:0] rd_reg;
   logic [1:0] op_sel;
   logic [5:0] funct_sel;

   logic [1:0] dec_alu_control, dec_flag_mask, dec_imm_src;
   logic       dec_is_cmp, dec_is_imm, dec_is_load, dec_illegal;

   // Fields are captured in DECODE; in DECODE itself the freshly written IR
   // is used directly so the branch to the execute path is known in time.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_reg    <= 2'b00;
         funct_reg <= 6'b000000;
         rd_reg    <= 4'h0;
      end else if (state_reg == S_DECODE) begin
         op_reg    <= Op;
         funct_reg <= Funct;
         rd_reg    <= Rd;
      end
   end

   assign op_sel    = (state_reg == S_DECODE) ? Op    : op_reg;
   assign funct_sel = (state_reg == S_DECODE) ? Funct : funct_reg;

   instr_decoder u_dec (
      .op          (op_sel),
      .funct       (funct_sel),
      .alu_control (dec_alu_control),
      .flag_mask   (dec_flag_mask),
      .imm_src     (dec_imm_src),
      .is_cmp      (dec_is_cmp),
      .is_imm      (dec_is_imm),
      .is_load     (dec_is_load),
      .illegal     (dec_illegal)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_FETCH:  if (MemReady) state_next = S_DECODE;
         S_DECODE: begin
            if (dec_illegal)           state_next = S_UNKNOWN;
            else if (op_sel == OP_MEM) state_next = S_MEMADR;
            else if (op_sel == OP_BR)  state_next = S_BRANCH;
            else if (dec_is_imm)       state_next = S_EXECI;
            else                       state_next = S_EXECR;
         end
         S_MEMADR: state_next = dec_is_load ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (MemReady) state_next = S_MEMWB;
         S_MEMWR:  if (MemReady) state_next = S_FETCH;
         S_EXECR,
         S_EXECI:  state_next = dec_is_cmp ? S_FETCH : S_ALUWB;
         S_MEMWB,
         S_ALUWB,
         S_BRANCH,
         S_UNKNOWN: state_next = S_FETCH;
         default:   state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= RESET_STATE;
      else       state_reg <= state_next;
   end

   // While reset is high the datapath selects show FETCH values and every
   // write enable is held low, whatever state the register still holds.
   assign out_state = reset ? S_FETCH : state_reg;

   always_comb begin
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = SRCA_RA;
      ALUSrcB    = SRCB_RD2;
      ALUControl = ALU_ADD;
      ResultSrc  = RES_ALUOUT;
      ImmSrc     = IMM_ROT;
      RegSrc     = 2'b00;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      FlagW      = 2'b00;
      Illegal    = 1'b0;
      case (out_state)
         S_FETCH: begin
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_PC;
            ALUSrcB = SRCB_FOUR;
         end
         S_MEMADR: begin
            ALUSrcB = SRCB_IMM;
            ImmSrc  = dec_imm_src;
         end
         S_MEMRD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = CondEx;
            PCWrite   = CondEx & (rd_reg == 4'hF);
         end
         S_MEMWR: begin
            AdrSrc   = 1'b1;
            RegSrc   = 2'b10;
            MemWrite = CondEx;
         end
         S_EXECR: begin
            ALUControl = dec_alu_control;
            FlagW      = dec_flag_mask & {2{CondEx}};
         end
         S_EXECI: begin
            ALUSrcB    = SRCB_IMM;
            ImmSrc     = dec_imm_src;
            ALUControl = dec_alu_control;
            FlagW      = dec_flag_mask & {2{CondEx}};
         end
         S_ALUWB: begin
            RegWrite = CondEx;
            PCWrite  = CondEx & (rd_reg == 4'hF);
         end
         S_BRANCH: begin
            ALUSrcA   = SRCA_ALT;
            ALUSrcB   = SRCB_IMM;
            ImmSrc    = dec_imm_src;
            RegSrc    = 2'b01;
            ResultSrc = RES_ALURESULT;
            PCWrite   = CondEx;
         end
         S_UNKNOWN: Illegal = 1'b1;
         default: ;
      endcase
      if (reset) begin
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         FlagW    = 2'b00;
         Illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: randomized self-checking bench for mc_control_fsm.
// Each instruction is expanded into its cycle-by-cycle phase plan from the
// instruction rules, and every cycle's control outputs are compared with
// values derived from that plan.
module tb_mc_control_fsm;

   localparam int P_FETCH = 0, P_DEC = 1, P_ADR = 2, P_RD = 3, P_WB = 4,
                  P_WR = 5, P_EX = 6, P_ALUWB = 7, P_BR = 8, P_UNK = 9;

   logic       clk = 1'b0;
   logic       reset, CondEx, MemReady;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       IRWrite, AdrSrc, PCWrite, RegWrite, MemWrite, Illegal;
   logic [1:0] ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc, FlagW;
   logic [19:0] obs;

   int n_checks = 0;
   int n_fail   = 0;
   int plan[$];
   logic [3:0] legal_cmds [5];

   always #5 clk = ~clk;

   mc_control_fsm dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
      .CondEx(CondEx), .MemReady(MemReady),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
      .RegSrc(RegSrc), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .FlagW(FlagW), .Illegal(Illegal)
   );

   assign obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc,
                 ImmSrc, RegSrc, PCWrite, RegWrite, MemWrite, FlagW, Illegal};

   task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %05h required %05h", tag, got, want);
      end
   endtask

   function automatic logic is_legal_cmd(input logic [3:0] cmd);
      return (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010) ||
             (cmd == 4'b0000) || (cmd == 4'b1100);
   endfunction

   // Phase sequence an instruction walks through (stall cycles excluded)
   function automatic void plan_instr(input logic [1:0] op, input logic [5:0] funct);
      plan.delete();
      plan.push_back(P_FETCH);
      plan.push_back(P_DEC);
      if (op == 2'b11 || (op == 2'b00 && !is_legal_cmd(funct[4:1]))) begin
         plan.push_back(P_UNK);
      end else if (op == 2'b01) begin
         plan.push_back(P_ADR);
         if (funct[0]) begin
            plan.push_back(P_RD);
            plan.push_back(P_WB);
         end else begin
            plan.push_back(P_WR);
         end
      end else if (op == 2'b10) begin
         plan.push_back(P_BR);
      end else begin
         plan.push_back(P_EX);
         if (funct[4:1] != 4'b1010) plan.push_back(P_ALUWB);
      end
   endfunction

   // Required control outputs for one cycle of a phase
   function automatic logic [19:0] expect_vec(input int ph, input logic rdy, input logic cond,
                                              input logic [5:0] funct, input logic [3:0] rd);
      logic       irw, adr, pcw, rw, mw, ill;
      logic [1:0] sa, sb, alu, res, imm, rs, fw, mask;
      irw = 0; adr = 0; pcw = 0; rw = 0; mw = 0; ill = 0;
      sa = 0; sb = 0; alu = 0; res = 0; imm = 0; rs = 0; fw = 0; mask = 0;
      case (funct[4:1])
         4'b0100: begin alu = 2'd0; mask = 2'b11; end
         4'b0010: begin alu = 2'd1; mask = 2'b11; end
         4'b1010: begin alu = 2'd1; mask = 2'b11; end
         4'b0000: begin alu = 2'd2; mask = 2'b10; end
         4'b1100: begin alu = 2'd3; mask = 2'b10; end
         default: begin alu = 2'd0; mask = 2'b00; end
      endcase
      case (ph)
         P_FETCH: begin sa = 2'b01; sb = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; alu = 0; end
         P_DEC:   begin sa = 2'b01; sb = 2'b10; alu = 0; end
         P_ADR:   begin sb = 2'b01; imm = 2'b01; alu = 0; end
         P_RD:    begin adr = 1; alu = 0; end
         P_WB:    begin res = 2'b01; rw = cond; pcw = cond && (rd == 4'hF); alu = 0; end
         P_WR:    begin adr = 1; rs = 2'b10; mw = cond; alu = 0; end
         P_EX:    begin sb = funct[5] ? 2'b01 : 2'b00; fw = (funct[0] && cond) ? mask : 2'b00; end
         P_ALUWB: begin rw = cond; pcw = cond && (rd == 4'hF); alu = 0; end
         P_BR:    begin sa = 2'b10; sb = 2'b01; imm = 2'b10; rs = 2'b01; res = 2'b10; pcw = cond; alu = 0; end
         default: begin ill = 1; alu = 0; end
      endcase
      return {irw, adr, sa, sb, alu, res, imm, rs, pcw, rw, mw, fw, ill};
   endfunction

   task automatic step(input string tag, input logic [19:0] want);
      @(negedge clk);
      check_eq(tag, obs, want);
      @(posedge clk);
      #1;
   endtask

   // stall < 0: random 0..2 stall cycles on every memory wait;
   // otherwise no fetch stalls and exactly 'stall' on MEMRD/MEMWR.
   task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                            input logic [3:0] rd, input logic cond, input int stall);
      int cycles = 0;
      int k;
      plan_instr(op, funct);
      Op = op; Funct = funct; Rd = rd; CondEx = cond;
      foreach (plan[i]) begin
         if (plan[i] == P_FETCH || plan[i] == P_RD || plan[i] == P_WR) begin
            k = (stall < 0) ? int'($urandom_range(0, 2)) : ((plan[i] == P_FETCH) ? 0 : stall);
            for (int s = 0; s < k; s++) begin
               MemReady = 1'b0;
               step($sformatf("%s/ph%0d/c%0d", name, plan[i], cycles),
                    expect_vec(plan[i], 1'b0, cond, funct, rd));
               cycles++;
            end
            MemReady = 1'b1;
         end else begin
            MemReady = 1'($urandom_range(0, 1));
         end
         step($sformatf("%s/ph%0d/c%0d", name, plan[i], cycles),
              expect_vec(plan[i], MemReady, cond, funct, rd));
         cycles++;
      end
      $display("instr %-10s op=%b funct=%b rd=%0d cond=%0d cycles=%0d", name, op, funct, rd, cond, cycles);
   endtask

   initial begin
      legal_cmds[0] = 4'b0100; legal_cmds[1] = 4'b0010; legal_cmds[2] = 4'b1010;
      legal_cmds[3] = 4'b0000; legal_cmds[4] = 4'b1100;

      // Reset held three cycles with MemReady high: enables stay low
      reset = 1'b1; MemReady = 1'b1; CondEx = 1'b1;
      Op = 2'b00; Funct = 6'b001000; Rd = 4'h0;
      for (int i = 0; i < 3; i++)
         step($sformatf("reset/c%0d", i), expect_vec(P_FETCH, 1'b0, 1'b1, Funct, Rd));
      reset = 1'b0;

      run_instr("add_nop",  2'b00, 6'b001000, 4'd1, 1'b1, 0);
      run_instr("ldr",      2'b01, 6'b011001, 4'd2, 1'b1, 0);
      run_instr("str_st2",  2'b01, 6'b011000, 4'd3, 1'b1, 2);
      run_instr("adds_c1",  2'b00, 6'b101001, 4'd4, 1'b1, 0);
      run_instr("adds_c0",  2'b00, 6'b101001, 4'd4, 1'b0, 0);
      run_instr("b_c1",     2'b10, 6'b101000, 4'd0, 1'b1, 0);
      run_instr("b_c0",     2'b10, 6'b101000, 4'd0, 1'b0, 0);
      run_instr("op11",     2'b11, 6'b000000, 4'd5, 1'b1, 0);
      run_instr("dp_bad",   2'b00, 6'b011110, 4'd5, 1'b1, 0);
      run_instr("add_pc",   2'b00, 6'b001000, 4'hF, 1'b1, 0);
      run_instr("ldr_pc",   2'b01, 6'b011001, 4'hF, 1'b1, 1);
      run_instr("cmp",      2'b00, 6'b010101, 4'd0, 1'b1, 0);
      run_instr("ands",     2'b00, 6'b000001, 4'd6, 1'b1, 0);

      // Reset during MEMRD: instruction is abandoned, no writeback
      plan_instr(2'b01, 6'b011001);
      Op = 2'b01; Funct = 6'b011001; Rd = 4'd7; CondEx = 1'b1; MemReady = 1'b1;
      step("rst_ldr/fetch", expect_vec(P_FETCH, 1'b1, 1'b1, Funct, Rd));
      step("rst_ldr/dec",   expect_vec(P_DEC,   1'b1, 1'b1, Funct, Rd));
      step("rst_ldr/adr",   expect_vec(P_ADR,   1'b1, 1'b1, Funct, Rd));
      MemReady = 1'b0;
      step("rst_ldr/rd",    expect_vec(P_RD,    1'b0, 1'b1, Funct, Rd));
      reset = 1'b1; MemReady = 1'b1;
      step("rst_ldr/rst0",  expect_vec(P_FETCH, 1'b0, 1'b1, Funct, Rd));
      step("rst_ldr/rst1",  expect_vec(P_FETCH, 1'b0, 1'b1, Funct, Rd));
      reset = 1'b0;
      $display("instr %-10s abandoned in MEMRD by reset", "rst_ldr");
      run_instr("after_rst", 2'b00, 6'b000100, 4'd8, 1'b1, 0);

      // Randomized instruction stream
      for (int n = 0; n < 150; n++) begin
         logic [1:0] op;
         logic [5:0] funct;
         op    = 2'($urandom_range(0, 3));
         funct = 6'($urandom);
         if (op == 2'b00 && $urandom_range(0, 3) != 0)
            funct[4:1] = legal_cmds[$urandom_range(0, 4)];
         run_instr($sformatf("rnd%0d", n), op, funct, 4'($urandom), 1'($urandom_range(0, 1)), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
